lsu: RTL and testbench
======================

# lsu

Load/store unit for the RV32I core, directly downstream of the ALU. It takes the effective address the ALU computes for load and store instructions (`in1 + imm`) and turns it into a single word-aligned data-bus transaction. It generates byte strobes and lane-replicated store data, and sign- or zero-extends load data. It then returns one response per accepted request to the writeback path.

## Interface
- `ADDR_W`, 32, width of `req_addr` and `mem_addr`.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`; equals (state == IDLE).
- `req_inst`  in  32  instruction word; `[6:0]` opcode, `[14:12]` funct3, `[11:7]` rd.
- `req_addr`  in  ADDR_W  effective address from the ALU.
- `req_wdata`  in  32  rs2 value for stores.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rd`  out  5  destination register; 0 for stores and errors.
- `resp_data`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  illegal opcode/funct3 or misaligned access.
- `mem_req`  out  1  bus request; held until `mem_ack`.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  ADDR_W  `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_wstrb`  out  4  byte-lane enables; 0 for loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  transaction complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, BUS, RESP. Reset and every completion return to IDLE.
- Request decode:
  - Opcode 0000011 is a load, with funct3 ∈ {LB 000, LH 001, LW 010, LBU 100, LHU 101}.
  - Opcode 0100011 is a store, with funct3 ∈ {SB 000, SH 001, SW 010}.
  - Any other opcode or funct3 is an error.
- Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0 (see Configuration).
- IDLE + handshake:
  - Error or misaligned request → RESP with `resp_err`=1. No bus access.
  - Otherwise register `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`, rd, funct3, `addr[1:0]` → BUS.
- BUS: `mem_req`=1, bus outputs stable. On `mem_ack` capture `mem_rdata` → RESP.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- Store strobes:
  - SB: `1<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: `addr[1]` ? 1100 : 0011, data `{2{wdata[15:0]}}`.
  - SW: 1111, data `wdata`.
- Load lane selection:
  - Byte lane = `rdata >> (8*addr[1:0])`; halfword lane = `addr[1]` ? `rdata[31:16]` : `rdata[15:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word.
- `mem_ack` outside BUS is ignored.

## Timing
- Reset values: state IDLE, so `req_ready`=1.
  - 0: `mem_req`, `mem_we`, `mem_wstrb`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_rd`, `resp_data`, `resp_err`.
- Accept at edge N → `mem_req` high from N+1.
- `mem_ack` sampled at edge M (M ≥ N+1) → `mem_req` low and `resp_valid` high after M; `resp_valid` drops after M+1.
- Zero-wait bus (ack in first BUS cycle): 3 cycles per access, 1 in IDLE, 1 in BUS, 1 in RESP.
- Error path: accept at N → `resp_valid` in N+1 → `req_ready` again in N+2.
- `req_ready`=0 in BUS and RESP; inputs ignored there.
- Reset asserted mid-transaction: at the next edge `mem_req` drops and the state returns to IDLE. No `resp_valid` is issued for the aborted access.

## Configuration
- `RUA_LSU_MISALIGN_CHECK_EN` defined:
  - Misaligned halfword/word requests return `resp_err`=1 with no bus activity.
- Not defined:
  - No misalignment error; the low address bits below the access size are ignored.
  - Halfword uses `addr[1]` only; word uses lane 0.
  - Normal bus access proceeds.

## Test plan
- SW addr 0x100, rs2 0xDEADBEEF, ack in first BUS cycle → `mem_addr` 0x100, `mem_wstrb` 1111, `mem_wdata` 0xDEADBEEF; `resp_valid` 2 cycles after accept with rd 0, err 0.
- SB addr 0x203, rs2 0x000000A5 → `mem_wstrb` 1000, `mem_wdata` 0xA5A5A5A5, `mem_addr` 0x200.
- LB/LBU addr 0x301, `mem_rdata` 0x12348000, rd 5:
  - `mem_rdata` byte 1 = 0x80 → LB `resp_data` 0xFFFFFF80, LBU 0x00000080, `resp_rd` 5.
  - LH addr 0x302 with `mem_rdata` 0x80011234 → `resp_data` 0xFFFF8001.
- LW with `mem_ack` delayed 4 cycles → `mem_req` and `mem_addr` stable throughout, `req_ready`=0, exactly one `resp_valid`.
- LW addr 0x101:
  - With macro: `resp_err`=1 one cycle after accept, `mem_req` never high.
  - Without macro: bus read at 0x100.
- Funct3 011 on a load, then reset asserted mid-BUS on a valid LW → first returns `resp_err`=1. After reset, `mem_req` is 0, `req_ready` is 1, and no `resp_valid` is issued.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: decodes a load/store, issues one word-aligned bus access, returns one response.
// Latency: accept -> BUS next cycle -> RESP the cycle after mem_ack (3 cycles zero-wait); errors skip BUS.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack; responses cannot be stalled.
// Optional feature macro: RUA_LSU_MISALIGN_CHECK_EN (misaligned half/word accesses report resp_err).
module lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_inst,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [4:0]        resp_rd,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state;
   logic [4:0]  rd_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [1:0]  off;
   logic        is_load;
   logic        is_store;
   logic        legal;
   logic        misalign;
   logic        dec_err;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [31:0] rd_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        unused;

   assign opc      = req_inst[6:0];
   assign f3       = req_inst[14:12];
   assign off      = req_addr[1:0];
   assign is_load  = (opc == 7'b0000011);
   assign is_store = (opc == 7'b0100011);
   assign legal    = (is_load  && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                   f3 == 3'b100 || f3 == 3'b101)) ||
                     (is_store && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010));
`ifdef RUA_LSU_MISALIGN_CHECK_EN
   assign misalign = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
`else
   // Without the check, sub-size address bits are simply dropped by lane selection.
   assign misalign = 1'b0;
`endif
   assign dec_err  = !legal || misalign;
   assign unused   = ^req_inst[31:15];

   assign req_ready  = (state == IDLE);
   assign mem_req    = (state == BUS);
   assign resp_valid = (state == RESP);

   // Store strobes and lane-replicated data from funct3 and the low address bits.
   always_comb begin
      st_strb = 4'b0000;
      st_data = 32'h0;
      case (f3)
         3'b000: begin
            st_strb = 4'b0001 << off;
            st_data = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            st_strb = off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            st_strb = 4'b1111;
            st_data = req_wdata;
         end
         default: ;
      endcase
   end

   // Load lane selection and sign/zero extension of the returned word.
   assign rd_shift = mem_rdata >> {off_q, 3'b000};
   assign ld_byte  = rd_shift[7:0];
   assign ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   always_comb begin
      ld_data = 32'h0;
      if (!mem_we) begin
         case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
         endcase
      end
   end

   // Control FSM plus registered bus request and response fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= 4'b0000;
         mem_wdata <= 32'h0;
         rd_q      <= 5'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         resp_rd   <= 5'd0;
         resp_data <= 32'h0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (dec_err) begin
                     resp_err  <= 1'b1;
                     resp_rd   <= 5'd0;
                     resp_data <= 32'h0;
                     state     <= RESP;
                  end else begin
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_we    <= is_store;
                     mem_wstrb <= is_store ? st_strb : 4'b0000;
                     mem_wdata <= is_store ? st_data : 32'h0;
                     rd_q      <= is_store ? 5'd0 : req_inst[11:7];
                     f3_q      <= f3;
                     off_q     <= off;
                     state     <= BUS;
                  end
               end
            end
            BUS: begin
               if (mem_ack) begin
                  resp_data <= ld_data;
                  resp_rd   <= rd_q;
                  resp_err  <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               resp_rd   <= 5'd0;
               resp_data <= 32'h0;
               resp_err  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then randomized requests against a reference model.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_inst;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [6:0] opc, input int f3, input int rd);
      logic [2:0] f;
      logic [4:0] r;
      logic [16:0] hi;
      f  = 3'(f3);
      r  = 5'(rd);
      hi = 17'($urandom);
      return {hi, f, r, opc};
   endfunction

   // Reference model: access size in bytes, aligned base lane, byte arithmetic.
   task automatic model(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, output bit err, output bit st,
                        output logic [3:0] strb, output logic [31:0] wd,
                        output logic [4:0] rdx, output logic [31:0] data);
      bit ld;
      int f3, sz, a, base;
      longint v, m;
      ld   = (inst[6:0] == 7'h03);
      st   = (inst[6:0] == 7'h23);
      f3   = int'(inst[14:12]);
      sz   = 1 << (f3 % 4);
      a    = int'(addr[1:0]);
      err  = !((ld && f3 inside {0, 1, 2, 4, 5}) || (st && f3 inside {0, 1, 2}));
`ifdef RUA_LSU_MISALIGN_CHECK_EN
      if (!err && (a % sz) != 0) err = 1'b1;
`endif
      base = (a / sz) * sz;
      strb = 4'b0000;
      wd   = 32'h0;
      rdx  = 5'd0;
      data = 32'h0;
      if (!err && st) begin
         strb = 4'(((1 << sz) - 1) << base);
         for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end else if (!err) begin
         rdx = inst[11:7];
         v = longint'(rdata) >> (8 * base);
         if (sz < 4) begin
            m = (longint'(1) << (8 * sz)) - 1;
            v = v & m;
            if (f3 < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~m;
         end
         data = 32'(v);
      end
   endtask

   // One full transaction; call at #1 after a rising edge with the DUT idle.
   task automatic do_req(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay);
      bit err, st;
      logic [3:0] strb;
      logic [31:0] wd, data;
      logic [4:0] rdx;
      model(inst, addr, wdata, rdata, err, st, strb, wd, rdx, data);
      req_valid = 1'b1; req_inst = inst; req_addr = addr; req_wdata = wdata;
      chk("ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (err) begin
         chk("err_mem_req", 32'(mem_req), 32'd0);
         chk("err_resp_valid", 32'(resp_valid), 32'd1);
         chk("err_resp_err", 32'(resp_err), 32'd1);
         chk("err_resp_rd", 32'(resp_rd), 32'd0);
         chk("err_resp_data", resp_data, 32'd0);
         @(posedge clk); #1;
         chk("err_resp_drop", 32'(resp_valid), 32'd0);
         chk("err_ready_back", 32'(req_ready), 32'd1);
         chk("err_mem_req2", 32'(mem_req), 32'd0);
      end else begin
         for (int d = 0; d <= delay; d++) begin
            chk("bus_mem_req", 32'(mem_req), 32'd1);
            chk("bus_ready", 32'(req_ready), 32'd0);
            chk("bus_resp_valid", 32'(resp_valid), 32'd0);
            chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
            chk("bus_we", 32'(mem_we), 32'(st));
            chk("bus_wstrb", 32'(mem_wstrb), 32'(strb));
            if (st) chk("bus_wdata", mem_wdata, wd);
            // Junk on the request port while busy must be ignored.
            req_valid = 1'($urandom); req_inst = $urandom; req_addr = $urandom; req_wdata = $urandom;
            mem_rdata = (d == delay) ? rdata : $urandom;
            mem_ack = (d == delay);
            @(posedge clk); #1;
         end
         mem_ack = 1'b0; req_valid = 1'b0; mem_rdata = $urandom;
         chk("resp_valid", 32'(resp_valid), 32'd1);
         chk("resp_mem_req", 32'(mem_req), 32'd0);
         chk("resp_err", 32'(resp_err), 32'd0);
         chk("resp_rd", 32'(resp_rd), 32'(rdx));
         chk("resp_data", resp_data, data);
         @(posedge clk); #1;
         chk("resp_drop", 32'(resp_valid), 32'd0);
         chk("ready_back", 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      logic [6:0] opc;
      rst_n = 1'b0; req_valid = 1'b0; req_inst = 32'h0; req_addr = 32'h0;
      req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rd", 32'(resp_rd), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases from the feature list.
      do_req(mk_inst(7'h23, 2, 3), 32'h100, 32'hDEADBEEF, 32'h0, 0);
      chk("sw_wdata_const", {24'h0, 8'hEF}, 32'hEF);
      do_req(mk_inst(7'h23, 0, 0), 32'h203, 32'h000000A5, 32'h0, 1);
      do_req(mk_inst(7'h03, 0, 5), 32'h301, 32'h0, 32'h12348000, 0);
      do_req(mk_inst(7'h03, 4, 5), 32'h301, 32'h0, 32'h12348000, 0);
      do_req(mk_inst(7'h03, 1, 7), 32'h302, 32'h0, 32'h80011234, 0);
      do_req(mk_inst(7'h03, 2, 9), 32'h400, 32'h0, 32'hCAFEF00D, 4);
      do_req(mk_inst(7'h03, 2, 9), 32'h101, 32'h0, 32'h55AA55AA, 0);
      do_req(mk_inst(7'h03, 3, 4), 32'h100, 32'h0, 32'h0, 0);

      // Ack while idle has no effect.
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
      chk("idle_ack_resp", 32'(resp_valid), 32'd0);

      // Reset in the middle of a bus access aborts it silently.
      req_valid = 1'b1; req_inst = mk_inst(7'h03, 2, 6); req_addr = 32'h800;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_in_bus", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_resp", 32'(resp_valid), 32'd0);
      rst_n = 1'b1; mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      chk("abort_no_req", 32'(mem_req), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         case ($urandom % 8)
            0, 1, 2, 3: opc = 7'h03;
            4, 5, 6:    opc = 7'h23;
            default:    opc = 7'($urandom);
         endcase
         do_req(mk_inst(opc, int'($urandom % 8), int'($urandom % 32)), $urandom, $urandom,
                $urandom, int'($urandom % 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
